// File: rtl/brazo_pkg.sv
// Shared types and constants for the servo playback path: FSM encodings,
// servo centre position, default step length and counter-width helper.
package brazo_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LIVE  = 3'd1;
  localparam state_t ST_FETCH = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [15:0] SERVO_CENTER     = 16'h8000;
  localparam int          STEP_CYCLES_DEF  = 1_000_000;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/servo_sequencer_if.sv
// Control, ROM and servo-output bundle between the sequencer and its neighbours.
interface servo_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              mode_play;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] seq_len;
  logic [15:0]       accel_x;
  logic [15:0]       accel_y;
  logic [15:0]       accel_z;
  logic [DATA_W-1:0] rom_data_x;
  logic [DATA_W-1:0] rom_data_y;
  logic [DATA_W-1:0] rom_data_z;
  logic [ADDR_W-1:0] rom_address;
  logic [15:0]       servo_x;
  logic [15:0]       servo_y;
  logic [15:0]       servo_z;
  logic              busy;
  logic              done;

  modport master (
    output mode_play, start, stop, loop_en, seq_len,
    output accel_x, accel_y, accel_z,
    output rom_data_x, rom_data_y, rom_data_z,
    input  rom_address, servo_x, servo_y, servo_z, busy, done
  );

  modport slave (
    input  mode_play, start, stop, loop_en, seq_len,
    input  accel_x, accel_y, accel_z,
    input  rom_data_x, rom_data_y, rom_data_z,
    output rom_address, servo_x, servo_y, servo_z, busy, done
  );
endinterface

// File: rtl/servo_slew.sv
// Rate limiter for one servo axis: walks the output toward the latest target
// by at most SLEW_STEP every SLEW_DIV cycles. Used only with SERVO_SLEW_EN.
module servo_slew
  import brazo_pkg::*;
#(
  parameter int          SLEW_DIV  = 50_000,
  parameter logic [15:0] SLEW_STEP = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] value
);
  localparam int TW = cnt_w(SLEW_DIV);

  logic [15:0]   tgt_q, tgt_d, cur_q, cur_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          tick;

  always_comb begin
    tick   = (tick_q == TW'(SLEW_DIV - 1));
    tick_d = tick ? '0 : tick_q + 1'b1;
    tgt_d  = load ? load_val : tgt_q;
    cur_d  = cur_q;
    // Clamp the final step so the output lands exactly on the target.
    if (tick) begin
      if (cur_q < tgt_q)
        cur_d = ((tgt_q - cur_q) > SLEW_STEP) ? cur_q + SLEW_STEP : tgt_q;
      else if (cur_q > tgt_q)
        cur_d = ((cur_q - tgt_q) > SLEW_STEP) ? cur_q - SLEW_STEP : tgt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q  <= SERVO_CENTER;
      cur_q  <= SERVO_CENTER;
      tick_q <= '0;
    end else begin
      tgt_q  <= tgt_d;
      cur_q  <= cur_d;
      tick_q <= tick_d;
    end
  end

  assign value = cur_q;
endmodule

// File: rtl/servo_sequencer.sv
// Servo playback controller: live accelerometer tracking or timed ROM replay.
// Optional output rate limiting is enabled by defining SERVO_SLEW_EN.
//
// state | meaning
// IDLE  | outputs hold, wait for mode or start
// LIVE  | servo outputs follow accel inputs
// FETCH | latch ROM words for the current address
// HOLD  | dwell until the step counter ends the step
// DONE  | one-cycle completion pulse, then IDLE
module servo_sequencer
  import brazo_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 8,
  parameter int          STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int          SLEW_DIV    = 50_000,
  parameter logic [15:0] SLEW_STEP   = 16'h0100
) (
  input  logic             clk,
  input  logic             rst,
  servo_sequencer_if.slave bus
);
  localparam int                CNT_W    = cnt_w(STEP_CYCLES);
  localparam logic [CNT_W-1:0]  STEP_END = CNT_W'(STEP_CYCLES - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ld;
  logic [15:0]        ld_x, ld_y, ld_z;
  logic               abort;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    ld_x    = bus.accel_x;
    ld_y    = bus.accel_y;
    ld_z    = bus.accel_z;
    abort   = bus.stop || !bus.mode_play;
    case (state_q)
      ST_IDLE: begin
        if (!bus.mode_play) begin
          state_d = ST_LIVE;
        end else if (bus.start && !bus.stop) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
      end
      ST_LIVE: begin
        ld = 1'b1;
        if (bus.mode_play) state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          ld      = 1'b1;
          ld_x    = 16'({bus.rom_data_x, 8'h00});
          ld_y    = 16'({bus.rom_data_y, 8'h00});
          ld_z    = 16'({bus.rom_data_z, 8'h00});
          cnt_d   = CNT_W'(1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == STEP_END) begin
          // An address beyond a shrunken seq_len is treated as the last step.
          if (addr_q < bus.seq_len) begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_FETCH;
          end else if (bus.loop_en) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rom_address = addr_q;
  assign bus.busy        = (state_q == ST_FETCH) || (state_q == ST_HOLD);
  assign bus.done        = (state_q == ST_DONE);

`ifdef SERVO_SLEW_EN
  servo_slew #(.SLEW_DIV(SLEW_DIV), .SLEW_STEP(SLEW_STEP)) u_slew_x (
    .clk(clk), .rst(rst), .load(ld), .load_val(ld_x), .value(bus.servo_x));
  servo_slew #(.SLEW_DIV(SLEW_DIV), .SLEW_STEP(SLEW_STEP)) u_slew_y (
    .clk(clk), .rst(rst), .load(ld), .load_val(ld_y), .value(bus.servo_y));
  servo_slew #(.SLEW_DIV(SLEW_DIV), .SLEW_STEP(SLEW_STEP)) u_slew_z (
    .clk(clk), .rst(rst), .load(ld), .load_val(ld_z), .value(bus.servo_z));
`else
  logic [15:0] servo_x_q, servo_x_d, servo_y_q, servo_y_d, servo_z_q, servo_z_d;

  always_comb begin
    servo_x_d = ld ? ld_x : servo_x_q;
    servo_y_d = ld ? ld_y : servo_y_q;
    servo_z_d = ld ? ld_z : servo_z_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      servo_x_q <= SERVO_CENTER;
      servo_y_q <= SERVO_CENTER;
      servo_z_q <= SERVO_CENTER;
    end else begin
      servo_x_q <= servo_x_d;
      servo_y_q <= servo_y_d;
      servo_z_q <= servo_z_d;
    end
  end

  assign bus.servo_x = servo_x_q;
  assign bus.servo_y = servo_y_q;
  assign bus.servo_z = servo_z_q;
`endif
endmodule

// File: tb/tb_servo_sequencer.sv
// Directed self-checking bench for servo_sequencer with STEP_CYCLES=4.
module tb_servo_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] rom_x [256];
  logic [7:0] rom_y [256];
  logic [7:0] rom_z [256];

  servo_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  servo_sequencer #(.ADDR_W(8), .DATA_W(8), .STEP_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data_x = rom_x[bus.rom_address];
  assign bus.rom_data_y = rom_y[bus.rom_address];
  assign bus.rom_data_z = rom_z[bus.rom_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] exp_x(input int k);
    logic [15:0] w;
    case (k)
      0:       w = 16'h0A00;
      1:       w = 16'h1400;
      default: w = 16'h1E00;
    endcase
    return w;
  endfunction

  initial begin
    for (int a = 0; a < 256; a++) begin
      rom_x[a] = 8'h00;
      rom_y[a] = 8'h00;
      rom_z[a] = 8'h00;
    end
    rom_x[0] = 8'd10; rom_x[1] = 8'd20; rom_x[2] = 8'd30;
    rom_y[0] = 8'h11; rom_y[1] = 8'h22; rom_y[2] = 8'h33;
    rom_z[0] = 8'h44; rom_z[1] = 8'h55; rom_z[2] = 8'h66;

    bus.mode_play = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.loop_en   = 1'b0;
    bus.seq_len   = 8'd2;
    bus.accel_x   = 16'h0000;
    bus.accel_y   = 16'h0000;
    bus.accel_z   = 16'h0000;

    step(); step();
    chk("rst_addr",   32'(bus.rom_address), 32'h0);
    chk("rst_servox", 32'(bus.servo_x), 32'h8000);
    chk("rst_servoz", 32'(bus.servo_z), 32'h8000);
    chk("rst_busy",   32'(bus.busy), 32'h0);
    chk("rst_done",   32'(bus.done), 32'h0);
    rst = 1'b0;

    // live tracking
    bus.mode_play = 1'b0;
    bus.accel_x   = 16'h1234;
    bus.accel_y   = 16'hBEEF;
    step();
    chk("idle_hold", 32'(bus.servo_x), 32'h8000);
    step();
    chk("live_x", 32'(bus.servo_x), 32'h1234);
    chk("live_y", 32'(bus.servo_y), 32'hBEEF);
    chk("live_busy", 32'(bus.busy), 32'h0);
    bus.accel_x = 16'h5678;
    step();
    chk("live_lat", 32'(bus.servo_x), 32'h5678);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("live_start_busy", 32'(bus.busy), 32'h0);
    step();
    chk("live_start_busy2", 32'(bus.busy), 32'h0);
    bus.mode_play = 1'b1;
    step();
    step();
    chk("to_idle_busy", 32'(bus.busy), 32'h0);

    // start and stop together from IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("ss_busy", 32'(bus.busy), 32'h0);
    step();
    chk("ss_busy2", 32'(bus.busy), 32'h0);
    chk("ss_servo", 32'(bus.servo_x), 32'h5678);

    // non-looping three-step sequence
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("seq_addr%0d", i), 32'(bus.rom_address), (i < 12) ? 32'(i / 4) : 32'd2);
      chk($sformatf("seq_busy%0d", i), 32'(bus.busy), (i < 12) ? 32'd1 : 32'd0);
      chk($sformatf("seq_done%0d", i), 32'(bus.done), (i == 12) ? 32'd1 : 32'd0);
      if (i >= 1)
        chk($sformatf("seq_sx%0d", i), 32'(bus.servo_x), 32'(exp_x(((i - 1) / 4 > 2) ? 2 : (i - 1) / 4)));
      if (i == 6)
        chk("seq_sy", 32'(bus.servo_y), 32'h2200);
      step();
    end
    chk("seq_hold_x", 32'(bus.servo_x), 32'h1E00);
    chk("seq_hold_z", 32'(bus.servo_z), 32'h6600);

    // looping, then stop in the second HOLD cycle of address 1
    bus.loop_en = 1'b1;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("loop_addr%0d", i), 32'(bus.rom_address), 32'((i / 4) % 3));
      chk($sformatf("loop_busy%0d", i), 32'(bus.busy), 32'd1);
      chk($sformatf("loop_done%0d", i), 32'(bus.done), 32'd0);
      if (i == 13)
        chk("loop_wrap_x", 32'(bus.servo_x), 32'h0A00);
      step();
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_busy", 32'(bus.busy), 32'h0);
    chk("stop_servo", 32'(bus.servo_x), 32'h1400);
    chk("stop_addr", 32'(bus.rom_address), 32'h1);
    step();
    chk("stop_busy2", 32'(bus.busy), 32'h0);

    // restart at address 0, then abort via mode_play
    bus.loop_en = 1'b0;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    chk("re_addr", 32'(bus.rom_address), 32'h0);
    chk("re_busy", 32'(bus.busy), 32'h1);
    step();
    chk("re_servo", 32'(bus.servo_x), 32'h0A00);
    bus.accel_x   = 16'h4321;
    bus.mode_play = 1'b0;
    step();
    chk("md_busy", 32'(bus.busy), 32'h0);
    chk("md_servo", 32'(bus.servo_x), 32'h0A00);
    step();
    step();
    chk("md_live", 32'(bus.servo_x), 32'h4321);
    bus.mode_play = 1'b1;
    step();
    step();

    // single-step sequence
    bus.seq_len = 8'd0;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("one_busy%0d", i), 32'(bus.busy), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("one_done%0d", i), 32'(bus.done), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("one_addr%0d", i), 32'(bus.rom_address), 32'd0);
      step();
    end
    chk("one_servo", 32'(bus.servo_x), 32'h0A00);

    // reset in the middle of a sequence
    bus.seq_len = 8'd2;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_addr_pre", 32'(bus.rom_address), 32'h1);
    rst = 1'b1;
    step();
    chk("mid_addr", 32'(bus.rom_address), 32'h0);
    chk("mid_servo", 32'(bus.servo_x), 32'h8000);
    chk("mid_busy", 32'(bus.busy), 32'h0);
    chk("mid_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
